scale_5_4_bilinear: RTL
=======================

SCALE_5_4_BILINEAR -- requirements
Module: scale_5_4_bilinear

Interface
REQ-001 SHALL have parameter LUMA_BITS, default 8: bits per luma sample.
REQ-002 SHALL have parameter MAX_INPUT_WIDTH, default 641: line-buffer depth in input pixels.
REQ-003 SHALL have parameter MAX_INPUT_HEIGHT, default 481: maximum input rows, used for coordinate sizing only.
REQ-004 SHALL have parameter COORD_BITS, default 11: width of all coordinate and dimension ports.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have ports r_width and r_height, input, COORD_BITS each: input frame dimensions, stable for the whole frame.
REQ-008 SHALL have ports in_pixel (input, LUMA_BITS), in_valid (input, 1), in_ready (output, 1), in_x and in_y (input, COORD_BITS each): raster-order input stream.
REQ-009 SHALL have ports out_pixel (output, LUMA_BITS), out_valid (output, 1), out_x and out_y (output, COORD_BITS each): raster-order upscaled stream, with no backpressure.

Function
REQ-010 SHALL upscale by 5/4 in both axes: output size Wo=(r_width-1)*5/4+1 by Ho=(r_height-1)*5/4+1; behaviour is undefined unless (r_width-1)%4==0, (r_height-1)%4==0 and r_width>=5.
REQ-011 SHALL accept a pixel only on a cycle with in_valid&&in_ready; in_valid while in_ready is low is ignored, with no data loss or duplication.
REQ-012 SHALL write each accepted pixel at address in_x of the current fill buffer; accepting in_x==0&&in_y==0 restarts the frame (row count 0, buffer pointer 0).
REQ-013 SHALL keep two ping-pong row buffers, each MAX_INPUT_WIDTH deep, holding "top" (row r) and "bottom" (row r+1).
REQ-014 SHALL implement FSM states IDLE, FILL, EMIT and LAST; in_ready is 1 in IDLE and FILL, and 0 in EMIT and LAST.
REQ-015 SHALL transition IDLE->FILL on the first accepted pixel, then FILL->EMIT on accepting in_x==r_width-1 of row r+1>=1; row 0 completion stays in FILL.
REQ-016 SHALL, in EMIT for top row r, emit output rows Y with floor(4Y/5)==r: two rows (q=0, then q=1) when r%4==0, otherwise one row with q=r%4+1.
REQ-017 SHALL, after the last EMIT issue, go to FILL with buffers swapped, or to LAST if row r+1==r_height-1.
REQ-018 SHALL, in LAST, emit row Y=Ho-1 from row r_height-1 with bottom weight 0, then go to IDLE.
REQ-019 SHALL issue exactly one output pixel per cycle in EMIT and LAST, in X order 0..Wo-1, with no gaps within a row.
REQ-020 SHALL compute output X from phase p=X%5 and source column c=4*(X/5)+{0,0,1,2,3}[p], using right weight wr={0,13,10,6,3}[p] and left weight 16-wr; vertical weights use q the same way.
REQ-021 SHALL clamp the column c+1 read to c when c==r_width-1; wr is then 0 there.
REQ-022 SHALL form out_pixel=(sum of pixel*wx*wy over the 2x2 window + 128)>>8 with sums at least LUMA_BITS+9 bits wide, never saturating or overflowing.
REQ-023 SHALL assert out_valid, with out_x=X and out_y=Y, exactly 4 cycles after the issue cycle; the pipeline drains independently of the FSM.

Reset
REQ-024 SHALL, while reset is low, force state IDLE, out_valid=0, out_pixel=0, out_x=0, out_y=0, and all pipeline valids to 0; in_ready SHALL be 1 after release.
REQ-025 SHALL NOT reset row-buffer contents; reset mid-EMIT drops all in-flight pixels and issues no further out_valid.

Verification
REQ-026 SHALL pass: 5x5 frame of constant 100 -> 36 out_valid pulses, all out_pixel=100, out_x/out_y covering 0..5 in raster order.
REQ-027 SHALL pass: 5x5 frame, every row 0,16,32,48,64 -> each output row X0..5 = 0,13,26,38,51,64.
REQ-028 SHALL pass: in_valid held high continuously -> in_ready drops at the end of row 1, each of the 25 pixels is accepted exactly once, and no pixel is lost.
REQ-029 SHALL pass: reset pulsed low during EMIT of row Y=1 -> out_valid=0 from assertion onward, and a fresh 5x5 frame afterwards yields the 36 correct pixels.
REQ-030 SHALL pass: 9x9 frame with row y = 16*y -> output column 0 for Y=0..10 = 0,13,26,38,51,64,77,90,102,115,128.

Source files
------------

// File: rtl/scale_5_4_bilinear.sv
// 5/4 bilinear luma upscaler: two ping-pong row buffers feed a 4-stage
// interpolation pipeline that emits one raster-order output pixel per cycle.
module scale_5_4_bilinear #(
  parameter int LUMA_BITS        = 8,
  parameter int MAX_INPUT_WIDTH  = 641,
  parameter int MAX_INPUT_HEIGHT = 481,
  parameter int COORD_BITS       = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [COORD_BITS-1:0] r_width,
  input  logic [COORD_BITS-1:0] r_height,
  input  logic [LUMA_BITS-1:0]  in_pixel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [COORD_BITS-1:0] in_x,
  input  logic [COORD_BITS-1:0] in_y,
  output logic [LUMA_BITS-1:0]  out_pixel,
  output logic                  out_valid,
  output logic [COORD_BITS-1:0] out_x,
  output logic [COORD_BITS-1:0] out_y
);

  localparam int ADDR_BITS = $clog2(MAX_INPUT_WIDTH);
  localparam int H_BITS    = LUMA_BITS + 4;
  localparam int S_BITS    = LUMA_BITS + 9;
  localparam logic [COORD_BITS-1:0] C_ONE  = COORD_BITS'(1);
  localparam logic [COORD_BITS-1:0] C_FOUR = COORD_BITS'(4);
  localparam logic [COORD_BITS-1:0] C_FIVE = COORD_BITS'(5);

  typedef enum logic [1:0] {IDLE, FILL, EMIT, LAST} state_t;

  // Right/bottom weight per phase, in 1/16ths.
  function automatic logic [4:0] weight(input logic [2:0] idx);
    case (idx)
      3'd1:    weight = 5'd13;
      3'd2:    weight = 5'd10;
      3'd3:    weight = 5'd6;
      3'd4:    weight = 5'd3;
      default: weight = 5'd0;
    endcase
  endfunction

  state_t state, state_n;
  logic                  fill_sel, second;
  logic [COORD_BITS-1:0] cur_row, y_cnt, x_cnt, col_base;
  logic [2:0]            phase;

  logic [LUMA_BITS-1:0] row_buf0 [MAX_INPUT_WIDTH];
  logic [LUMA_BITS-1:0] row_buf1 [MAX_INPUT_WIDTH];

  logic                  accept, start, row_end, issue, x_last, two_rows;
  logic                  emit_done, last_row, top_sel, bot_sel;
  logic [COORD_BITS-1:0] wo_last, c_col, c_col1;
  logic [2:0]            col_off, q;
  logic [1:0]            top_r2;
  logic [4:0]            wx, wy;

  assign accept   = in_valid && in_ready;
  assign start    = accept && (in_x == '0) && (in_y == '0);
  assign row_end  = accept && (in_x == r_width - C_ONE);
  assign wo_last  = ((r_width - C_ONE) >> 2) * C_FIVE;
  assign x_last   = (x_cnt == wo_last);
  assign top_r2   = cur_row[1:0] - 2'd1;
  assign two_rows = (top_r2 == 2'd0);
  assign emit_done = (state == EMIT) && x_last && (!two_rows || second);
  assign last_row  = (cur_row == r_height - C_ONE) ||
                     (cur_row == COORD_BITS'(MAX_INPUT_HEIGHT - 1));

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // FSM: next state
  always_comb begin
    // NOTE: default assignment first so no path leaves state_n unassigned (no latch).
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = FILL;
      FILL: if (row_end && cur_row != '0) state_n = EMIT;
      EMIT: if (emit_done) state_n = last_row ? LAST : FILL;
      LAST: if (x_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = (state == IDLE) || (state == FILL);
    issue    = (state == EMIT) || (state == LAST);
  end

  // Row/column bookkeeping. After an EMIT the old top buffer becomes the fill buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_sel <= 1'b0;
      second   <= 1'b0;
      cur_row  <= '0;
      y_cnt    <= '0;
      x_cnt    <= '0;
      col_base <= '0;
      phase    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (start) begin
        fill_sel <= 1'b0;
        second   <= 1'b0;
        cur_row  <= '0;
        y_cnt    <= '0;
        x_cnt    <= '0;
        col_base <= '0;
        phase    <= '0;
      end else if (row_end && cur_row == '0) begin
        fill_sel <= ~fill_sel;
        cur_row  <= C_ONE;
      end
      if (issue) begin
        if (x_last) begin
          x_cnt    <= '0;
          col_base <= '0;
          phase    <= '0;
          y_cnt    <= y_cnt + C_ONE;
          second   <= (state == EMIT) && two_rows && !second;
        end else begin
          x_cnt <= x_cnt + C_ONE;
          if (phase == 3'd4) begin
            phase    <= '0;
            col_base <= col_base + C_FOUR;
          end else begin
            phase <= phase + 3'd1;
          end
        end
        if (emit_done && !last_row) begin
          fill_sel <= ~fill_sel;
          cur_row  <= cur_row + C_ONE;
        end
      end
    end
  end

  // Issue-cycle source columns and weights; LAST reuses the final row as its own bottom.
  always_comb begin
    case (phase)
      3'd2:    col_off = 3'd1;
      3'd3:    col_off = 3'd2;
      3'd4:    col_off = 3'd3;
      default: col_off = 3'd0;
    endcase
    c_col   = col_base + COORD_BITS'(col_off);
    c_col1  = (c_col == r_width - C_ONE) ? c_col : c_col + C_ONE;
    wx      = weight(phase);
    q       = two_rows ? {2'b00, second} : {1'b0, top_r2} + 3'd1;
    wy      = (state == LAST) ? 5'd0 : weight(q);
    top_sel = (state == LAST) ? fill_sel : ~fill_sel;
    bot_sel = fill_sel;
  end

  // NOTE: row buffers are plain RAM and deliberately have no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (start ? 1'b0 : fill_sel) row_buf1[in_x[ADDR_BITS-1:0]] <= in_pixel;
      else                         row_buf0[in_x[ADDR_BITS-1:0]] <= in_pixel;
    end
  end

  logic [LUMA_BITS-1:0] s1_tl, s1_tr, s1_bl, s1_br;
  logic [4:0]           s1_wx, s1_wy, s2_wy;
  logic [H_BITS-1:0]    s2_top, s2_bot;
  logic [S_BITS-1:0]    s3_sum;

  always_ff @(posedge clk) begin
    s1_tl  <= top_sel ? row_buf1[c_col[ADDR_BITS-1:0]]  : row_buf0[c_col[ADDR_BITS-1:0]];
    s1_tr  <= top_sel ? row_buf1[c_col1[ADDR_BITS-1:0]] : row_buf0[c_col1[ADDR_BITS-1:0]];
    s1_bl  <= bot_sel ? row_buf1[c_col[ADDR_BITS-1:0]]  : row_buf0[c_col[ADDR_BITS-1:0]];
    s1_br  <= bot_sel ? row_buf1[c_col1[ADDR_BITS-1:0]] : row_buf0[c_col1[ADDR_BITS-1:0]];
    s1_wx  <= wx;
    s1_wy  <= wy;
    s2_top <= H_BITS'(s1_tl) * H_BITS'(5'd16 - s1_wx) + H_BITS'(s1_tr) * H_BITS'(s1_wx);
    s2_bot <= H_BITS'(s1_bl) * H_BITS'(5'd16 - s1_wx) + H_BITS'(s1_br) * H_BITS'(s1_wx);
    s2_wy  <= s1_wy;
    s3_sum <= S_BITS'(s2_top) * S_BITS'(5'd16 - s2_wy) + S_BITS'(s2_bot) * S_BITS'(s2_wy);
  end

  logic                  s1_valid, s2_valid, s3_valid;
  logic [COORD_BITS-1:0] s1_x, s2_x, s3_x, s1_y, s2_y, s3_y;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      {s1_valid, s2_valid, s3_valid, out_valid} <= '0;
      {s1_x, s2_x, s3_x, out_x} <= '0;
      {s1_y, s2_y, s3_y, out_y} <= '0;
      out_pixel <= '0;
    end else begin
      s1_valid  <= issue;
      s1_x      <= x_cnt;
      s1_y      <= y_cnt;
      s2_valid  <= s1_valid;
      s2_x      <= s1_x;
      s2_y      <= s1_y;
      s3_valid  <= s2_valid;
      s3_x      <= s2_x;
      s3_y      <= s2_y;
      out_valid <= s3_valid;
      out_x     <= s3_x;
      out_y     <= s3_y;
      out_pixel <= LUMA_BITS'((s3_sum + S_BITS'(128)) >> 8);
    end
  end

endmodule
